// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master among NUM_REQ requesters
// Optional transfer timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      timeout_err,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_tx,
  input  logic [DATA_W-1:0]         spi_rx,
  input  logic                      spi_done,
  input  logic                      spi_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             tmo_hit;

  // Scan from farthest to nearest so the last hit is the first index after last_owner.
  always_comb begin
    win_idx   = last_owner;
    win_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NUM_REQ]) begin
        win_idx   = IDX_W'((int'(last_owner) + k) % NUM_REQ);
        win_valid = 1'b1;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counter rests at zero in IDLE, so it starts from zero on every START entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE)
        tmo_cnt <= '0;
      else if (state == START || state == WAIT)
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (tmo_hit && !spi_done)
        timeout_err <= 1'b1;
    end
  end

  assign tmo_hit = (state == START || state == WAIT) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      spi_start  <= 1'b0;
      spi_tx     <= '0;
      rx_data    <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt       <= NUM_REQ'(1) << win_idx;
            owner     <= win_idx;
            spi_tx    <= req_data[int'(win_idx)*DATA_W +: DATA_W];
            spi_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          // A completion that beats the busy handshake still ends the transfer.
          if (spi_done) begin
            rx_data   <= spi_rx;
            spi_start <= 1'b0;
            done      <= gnt;
            state     <= FINISH;
          end else if (tmo_hit) begin
            spi_start <= 1'b0;
            done      <= gnt;
            state     <= FINISH;
          end else if (spi_busy) begin
            spi_start <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (spi_done) begin
            rx_data <= spi_rx;
            done    <= gnt;
            state   <= FINISH;
          end else if (tmo_hit) begin
            done  <= gnt;
            state <= FINISH;
          end
        end
        FINISH: begin
          gnt        <= '0;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SPI master.
REQ-002 Parameter DATA_W, default 16: SPI word width, equal to the SPI master data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: clk cycles allowed per transfer before abort.
REQ-004 clk  in  1  system clock, 24 MHz from the HF oscillator; all logic on the rising edge; synchronous, active-high reset.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester transfer request, level.
REQ-007 req_data  in  NUM_REQ*DATA_W  per-requester TX word; requester i uses bits [i*DATA_W +: DATA_W].
REQ-008 gnt  out  NUM_REQ  one-hot owner of the current transfer.
REQ-009 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-010 rx_data  out  DATA_W  last received word, valid from the done pulse until the next done.
REQ-011 timeout_err  out  1  one-cycle pulse on transfer abort.
REQ-012 spi_start  out  1  to SPI master start_transfer.
REQ-013 spi_tx  out  DATA_W  to SPI master data_to_tx.
REQ-014 spi_rx  in  DATA_W  from SPI master data_rx.
REQ-015 spi_done  in  1  from SPI master transfer_done.
REQ-016 spi_busy  in  1  from SPI master transfer_busy.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, FINISH.
REQ-018 IDLE: if any req is high, latch the round-robin winner into gnt, latch its req_data into spi_tx, and go to START next cycle; otherwise stay in IDLE.
REQ-019 Round robin: search begins at index (last_owner+1) mod NUM_REQ, wrapping; the lowest index reached first wins.
REQ-020 START: hold spi_start=1 until spi_busy=1 is sampled, then drive spi_start=0 and go to WAIT.
REQ-021 WAIT: on spi_done=1, latch spi_rx into rx_data and go to FINISH.
REQ-022 FINISH: pulse done[owner] for exactly one cycle, set last_owner=owner, clear gnt, and return to IDLE.
REQ-023 Minimum arbitration overhead: 3 cycles between spi_done and the next spi_start assertion.
REQ-024 spi_tx and gnt SHALL remain stable from START entry until FINISH exit.
REQ-025 req deasserted by the owner mid-transfer: the transfer completes and done still pulses.
REQ-026 spi_done arriving in START (before busy is seen): treat as completion and go to FINISH.
REQ-027 At most one bit of gnt and one bit of done SHALL be high in any cycle.
REQ-028 A requester with req held continuously SHALL be served within NUM_REQ transfers.

Reset
REQ-029 On reset: state=IDLE, gnt=0, done=0, spi_start=0, spi_tx=0, rx_data=0, timeout_err=0, last_owner=NUM_REQ-1 (requester 0 wins first).
REQ-030 Reset mid-transfer SHALL drop spi_start the next cycle, issue no done pulse, and return to IDLE.

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN, when defined, adds a cycle counter cleared on START entry and counting in START and WAIT.
REQ-032 With SPI_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES: spi_start=0, go to FINISH, pulse done[owner] and timeout_err together, and leave rx_data unchanged.
REQ-033 Without SPI_ARB_TIMEOUT_EN: no counter is synthesized, timeout_err is tied to 0, and the FSM waits indefinitely.

Verification
REQ-034 Single request: req=4'b0001, req_data[15:0]=0x0019, SPI model returns 0xA5A5 -> spi_tx=0x0019, gnt=0001, done[0] one pulse, rx_data=0xA5A5.
REQ-035 Contention: req=4'b1111 held after reset -> grant order 0,1,2,3,0; exactly one done per transfer.
REQ-036 Drop mid-transfer: req[2] deasserts during WAIT -> transfer finishes, done[2] pulses, next grant goes to another requester.
REQ-037 Reset mid-transfer: reset asserted in WAIT -> next cycle spi_start=0, gnt=0, no done; after release, requester 0 wins first.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16, model never raises spi_done) -> timeout_err and done[owner] pulse 16 cycles after START entry, rx_data unchanged.
REQ-039 Back-to-back: req=4'b0011, spi_done at cycle T -> next spi_start at T+3, gnt=0010.
